speech_mailbox: RTL and testbench

SPEECH_MAILBOX -- requirements
Module: speech_mailbox

---
 rtl/speech_mailbox_if.sv | 21 ++
 rtl/speech_mailbox.sv | 113 +++++++++++
 tb/tb_speech_mailbox.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/speech_mailbox_if.sv
// CPC-to-ATMega speech mailbox bus: CPC write strobe and data, ATMega pop strobe,
// and the registered FIFO head/status returned to both sides.
interface speech_mailbox_if;
  logic       iSPEECH_WRITE;
  logic [7:0] iCPC_DATA;
  logic       iBYTE_ACK;
  logic [7:0] oATMEGA_DATA;
  logic       oBYTE_READY;
  logic       oFULL;
  logic [7:0] oSTATUS;

  modport master (
    output iSPEECH_WRITE, iCPC_DATA, iBYTE_ACK,
    input  oATMEGA_DATA, oBYTE_READY, oFULL, oSTATUS
  );

  modport slave (
    input  iSPEECH_WRITE, iCPC_DATA, iBYTE_ACK,
    output oATMEGA_DATA, oBYTE_READY, oFULL, oSTATUS
  );
endinterface

// File: rtl/speech_mailbox.sv
// CPC-to-ATMega speech byte mailbox: a DEPTH-slot FIFO fed by synchronized asynchronous strobes.
// Define SPEECH_MAILBOX_OVF_FLAG_EN to add the sticky overflow flag on oSTATUS[5].
module speech_mailbox #(
  parameter int DEPTH = 4
) (
  input  logic            iCLK,
  input  logic            i__RESET,
  speech_mailbox_if.slave bus
);
  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [1:0]       wr_sync, ack_sync;
  logic             wr_prev, ack_prev;
  logic             wr_armed, ack_armed;
  logic [1:0]       warm;
  logic             push, pop, push_ok, pop_ok;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [3:0]       count, count_nxt;
  logic [7:0]       mem [DEPTH];
  logic [7:0]       head_q, status_q;
  logic             ready_q, full_q;
  logic             ovf;

  // A channel arms only after its synchronizer has captured a genuine low since reset,
  // so a strobe already high at release never looks like a fresh rising edge.
  always_ff @(posedge iCLK or negedge i__RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i__RESET) begin
      wr_sync   <= 2'b00;
      ack_sync  <= 2'b00;
      wr_prev   <= 1'b0;
      ack_prev  <= 1'b0;
      wr_armed  <= 1'b0;
      ack_armed <= 1'b0;
      warm      <= 2'b00;
    end else begin
      wr_sync  <= {wr_sync[0], bus.iSPEECH_WRITE};
      ack_sync <= {ack_sync[0], bus.iBYTE_ACK};
      wr_prev  <= wr_sync[1];
      ack_prev <= ack_sync[1];
      warm     <= {warm[0], 1'b1};
      if (warm[1] && !wr_sync[1])  wr_armed  <= 1'b1;
      if (warm[1] && !ack_sync[1]) ack_armed <= 1'b1;
    end
  end

  assign push    = wr_sync[1] & ~wr_prev & wr_armed;
  assign pop     = ack_sync[1] & ~ack_prev & ack_armed;
  assign pop_ok  = pop && (count != 4'd0);
  assign push_ok = push && (count != FULL_CNT);

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 4'd1;
      2'b01:   count_nxt = count - 4'd1;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge i__RESET) begin
    if (!i__RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // NOTE: storage has no reset; count and pointers alone decide which slots hold valid bytes.
  always_ff @(posedge iCLK) begin
    if (push_ok) mem[wr_ptr] <= bus.iCPC_DATA;
  end

`ifdef SPEECH_MAILBOX_OVF_FLAG_EN
  logic drop;
  assign drop = push && (count == FULL_CNT);

  // A dropped push outranks a clearing pop in the same cycle.
  always_ff @(posedge iCLK or negedge i__RESET) begin
    if (!i__RESET)   ovf <= 1'b0;
    else if (drop)   ovf <= 1'b1;
    else if (pop_ok) ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

  // Outputs trail the FIFO state by one cycle; the head holds its last byte while empty.
  always_ff @(posedge iCLK or negedge i__RESET) begin
    if (!i__RESET) begin
      head_q   <= 8'h00;
      ready_q  <= 1'b0;
      full_q   <= 1'b0;
      status_q <= 8'h00;
    end else begin
      ready_q  <= (count != 4'd0);
      full_q   <= (count == FULL_CNT);
      status_q <= {count == FULL_CNT, count != 4'd0, ovf, 1'b0, count};
      if (count != 4'd0) head_q <= mem[rd_ptr];
    end
  end

  assign bus.oATMEGA_DATA = head_q;
  assign bus.oBYTE_READY  = ready_q;
  assign bus.oFULL        = full_q;
  assign bus.oSTATUS      = status_q;
endmodule

// File: tb/tb_speech_mailbox.sv
// Self-checking bench for speech_mailbox: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then randomized strobe traffic.
`timescale 1ns/100ps
module tb_speech_mailbox;
  localparam int DEPTH = 4;
`ifdef SPEECH_MAILBOX_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  speech_mailbox_if bus ();

  speech_mailbox #(.DEPTH(DEPTH)) dut (
    .iCLK     (clk),
    .i__RESET (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] q[$];
  bit         ovf_m;
  logic       exp_ready, exp_full;
  logic [7:0] exp_status, exp_head;
  logic [7:0] push_sched [int];
  bit         pop_sched [int];
  bit         w_armed, a_armed, chk_en;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ovf_m      = 1'b0;
    exp_ready  = 1'b0;
    exp_full   = 1'b0;
    exp_status = 8'h00;
    exp_head   = 8'h00;
  endtask

  // Operations land on the 3rd edge after the strobe rise; outputs show the queue one edge later.
  task automatic model_loop();
    int n;
    bit pop_ok, push_ok, dropped;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_clear();
      else begin
        n          = q.size();
        exp_ready  = (n != 0);
        exp_full   = (n == DEPTH);
        exp_status = {exp_full, exp_ready, ovf_m & OVF_EN, 1'b0, 4'(n)};
        if (n != 0) exp_head = q[0];
        pop_ok  = pop_sched.exists(cyc) && (n > 0);
        push_ok = push_sched.exists(cyc) && (n < DEPTH);
        dropped = push_sched.exists(cyc) && (n == DEPTH);
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(push_sched[cyc]);
        if (dropped)     ovf_m = 1'b1;
        else if (pop_ok) ovf_m = 1'b0;
      end
    end
  endtask

  task automatic reset_watch();
    forever begin
      @(negedge rst_n);
      model_clear();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("ready",  bus.oBYTE_READY,  exp_ready);
        check("full",   bus.oFULL,        exp_full);
        check("status", bus.oSTATUS,      exp_status);
        check("head",   bus.oATMEGA_DATA, exp_head);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ready",  bus.oBYTE_READY,  8'h00);
    check("rst_full",   bus.oFULL,        8'h00);
    check("rst_status", bus.oSTATUS,      8'h00);
    check("rst_head",   bus.oATMEGA_DATA, 8'h00);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    w_armed = 1'b1;
    a_armed = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Called just after a falling edge; leaves the inputs low and idle at a falling edge.
  task automatic do_pulse(input bit w, input bit a, input logic [7:0] d, input int hi, input int lo);
    if (w) begin
      bus.iCPC_DATA     = d;
      bus.iSPEECH_WRITE = 1'b1;
      if (w_armed) push_sched[cyc + 3] = d;
    end
    if (a) begin
      bus.iBYTE_ACK = 1'b1;
      if (a_armed) pop_sched[cyc + 3] = 1'b1;
    end
    repeat (hi) @(negedge clk);
    bus.iSPEECH_WRITE = 1'b0;
    bus.iBYTE_ACK     = 1'b0;
    repeat (lo) @(negedge clk);
    w_armed = 1'b1;
    a_armed = 1'b1;
  endtask

  task automatic push_b(input logic [7:0] d);
    do_pulse(1'b1, 1'b0, d, 5, 4);
  endtask

  task automatic pop_b();
    do_pulse(1'b0, 1'b1, 8'h00, 5, 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int mode;
    bus.iSPEECH_WRITE = 1'b0;
    bus.iBYTE_ACK     = 1'b0;
    bus.iCPC_DATA     = 8'h00;
    model_clear();
    fork
      model_loop();
      reset_watch();
      compare_loop();
    join_none
    apply_reset();
    chk_en = 1'b1;

    // Single write: ready exactly four cycles after the strobe rise.
    bus.iCPC_DATA     = 8'hA5;
    bus.iSPEECH_WRITE = 1'b1;
    push_sched[cyc + 3] = 8'hA5;
    repeat (3) @(negedge clk);
    check("lat3_ready", bus.oBYTE_READY, 8'h00);
    @(negedge clk);
    check("lat4_ready", bus.oBYTE_READY, 8'h01);
    check("lat4_head", bus.oATMEGA_DATA, 8'hA5);
    check("lat4_status", bus.oSTATUS, 8'h41);
    repeat (4) @(negedge clk);
    bus.iSPEECH_WRITE = 1'b0;
    repeat (5) @(negedge clk);

    // Fill to DEPTH, then drain in order.
    apply_reset();
    for (int i = 1; i <= 4; i++) push_b(8'(i));
    check("fill_full", bus.oFULL, 8'h01);
    check("fill_status", bus.oSTATUS, 8'hC4);
    check("fill_head", bus.oATMEGA_DATA, 8'h01);
    pop_b();
    check("drain_head2", bus.oATMEGA_DATA, 8'h02);
    check("drain_status3", bus.oSTATUS, 8'h43);
    pop_b();
    check("drain_head3", bus.oATMEGA_DATA, 8'h03);
    pop_b();
    check("drain_head4", bus.oATMEGA_DATA, 8'h04);
    pop_b();
    check("drain_ready", bus.oBYTE_READY, 8'h00);
    check("drain_status", bus.oSTATUS, 8'h00);
    check("drain_hold", bus.oATMEGA_DATA, 8'h04);

    // Push into a full FIFO is dropped; a pop clears the overflow flag.
    apply_reset();
    for (int i = 1; i <= 4; i++) push_b(8'(i));
    push_b(8'hEE);
    check("ovf_status", bus.oSTATUS, OVF_EN ? 8'hE4 : 8'hC4);
    check("ovf_head", bus.oATMEGA_DATA, 8'h01);
    pop_b();
    check("ovf_clr_status", bus.oSTATUS, 8'h43);
    check("ovf_clr_head", bus.oATMEGA_DATA, 8'h02);
    push_b(8'hAB);
    do_pulse(1'b1, 1'b1, 8'hCD, 5, 4);
    check("full_both_status", bus.oSTATUS, OVF_EN ? 8'h63 : 8'h43);
    check("full_both_head", bus.oATMEGA_DATA, 8'h03);

    // Aligned push and pop with two bytes queued.
    apply_reset();
    push_b(8'h11);
    push_b(8'h22);
    do_pulse(1'b1, 1'b1, 8'h77, 5, 4);
    check("both_status", bus.oSTATUS, 8'h42);
    check("both_head", bus.oATMEGA_DATA, 8'h22);
    pop_b();
    check("both_head77", bus.oATMEGA_DATA, 8'h77);
    pop_b();
    check("both_empty", bus.oSTATUS, 8'h00);

    // Pop on empty changes nothing; a brief mid-cycle reset clears everything at once.
    pop_b();
    check("empty_pop_status", bus.oSTATUS, 8'h00);
    check("empty_pop_head", bus.oATMEGA_DATA, 8'h77);
    push_b(8'h31);
    push_b(8'h32);
    push_b(8'h33);
    check("three_status", bus.oSTATUS, 8'h43);
    #1 rst_n = 1'b0;
    #0.5;
    check("mid_rst_ready", bus.oBYTE_READY, 8'h00);
    check("mid_rst_full", bus.oFULL, 8'h00);
    check("mid_rst_status", bus.oSTATUS, 8'h00);
    check("mid_rst_head", bus.oATMEGA_DATA, 8'h00);
    #0.5 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Strobe held across reset release must not push; the next pulse does.
    rst_n             = 1'b0;
    w_armed           = 1'b0;
    bus.iCPC_DATA     = 8'h33;
    bus.iSPEECH_WRITE = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("held_ready", bus.oBYTE_READY, 8'h00);
    check("held_status", bus.oSTATUS, 8'h00);
    bus.iSPEECH_WRITE = 1'b0;
    repeat (5) @(negedge clk);
    w_armed = 1'b1;
    push_b(8'h44);
    check("after_held_status", bus.oSTATUS, 8'h41);
    check("after_held_head", bus.oATMEGA_DATA, 8'h44);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 250; i++) begin
      mode = $urandom_range(0, 19);
      if (mode == 19) apply_reset();
      else if (mode < 9)
        do_pulse(1'b1, 1'b0, 8'($urandom), $urandom_range(4, 6), $urandom_range(4, 6));
      else if (mode < 15)
        do_pulse(1'b0, 1'b1, 8'h00, $urandom_range(4, 6), $urandom_range(4, 6));
      else
        do_pulse(1'b1, 1'b1, 8'($urandom), $urandom_range(4, 6), $urandom_range(4, 6));
    end
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
